uart_param_frame_loader: RTL and testbench

- Sits between the UART receiver and the exposition, HV-hold and SPI-resistor blocks.
- Collects one framed parameter set from the UART byte stream and validates its header and checksum.
- On a good frame, updates del1, dur1, thhv and res_value together in one cycle; outputs never hold a half-written parameter set.
- Also flags the single-byte echo query "r" (0x72) for the UART TX path.

---
 rtl/uart_param_frame_loader_if.sv | 28 ++
 rtl/uart_param_frame_loader.sv | 166 ++++++++++++++++
 tb/tb_uart_param_frame_loader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_param_frame_loader_if.sv
// Byte stream from the UART receiver plus the parameter set and status
// presented to the exposition, HV-hold, SPI-resistor and UART TX blocks.
interface uart_param_frame_loader_if;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic [32:0] del1;
   logic [32:0] dur1;
   logic [7:0]  thhv;
   logic [7:0]  res_value;
   logic        load_pulse;
   logic        params_valid;
   logic        frame_err;
   logic [7:0]  err_cnt;
   logic        echo_req;
   logic        busy;

   modport master (
      output rx_data, rx_ready,
      input  del1, dur1, thhv, res_value, load_pulse, params_valid,
             frame_err, err_cnt, echo_req, busy
   );

   modport slave (
      input  rx_data, rx_ready,
      output del1, dur1, thhv, res_value, load_pulse, params_valid,
             frame_err, err_cnt, echo_req, busy
   );
endinterface

// File: rtl/uart_param_frame_loader.sv
// Assembles a 12-byte sync/payload/XOR-checksum frame from the UART byte
// stream and publishes the whole parameter set atomically on a good frame.
module uart_param_frame_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 5000000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter logic [7:0]  ECHO_BYTE      = 8'h72,
   parameter bit          REVERSE_BITS   = 1'b1
) (
   input logic                      clk,
   input logic                      reset,
   uart_param_frame_loader_if.slave bus
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PAYLOAD,
      CHECK
   } state_t;

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t           state;
   logic             rx_ready_q;
   logic [3:0]       idx;
   logic [7:0]       csum;
   logic [CNT_W-1:0] tmo_cnt;
   logic [7:0]       shadow [10];

   logic [32:0]      del1_q;
   logic [32:0]      dur1_q;
   logic [7:0]       thhv_q;
   logic [7:0]       res_q;
   logic             load_pulse_q;
   logic             params_valid_q;
   logic             frame_err_q;
   logic [7:0]       err_cnt_q;
   logic             echo_req_q;
   logic             busy_q;

   logic             rx_edge_p0;
   logic [7:0]       rx_byte_p0;
   logic             tmo_hit_p0;

   // Stage p0: byte strobe from the receiver's ready level, optional bit reversal
   assign rx_edge_p0 = bus.rx_ready & ~rx_ready_q;
   assign rx_byte_p0 = REVERSE_BITS ? rev8(bus.rx_data) : bus.rx_data;
   assign tmo_hit_p0 = (tmo_cnt == TMO_LAST);

   // Shadow payload is pure data: only a completed, verified frame exposes it.
   always_ff @(posedge clk) begin
      if (state == PAYLOAD && rx_edge_p0) begin
         shadow[idx] <= rx_byte_p0;
      end
   end

   // Stage p1: frame FSM with registered outputs and strobes
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         rx_ready_q     <= 1'b1;
         idx            <= 4'd0;
         csum           <= 8'd0;
         tmo_cnt        <= '0;
         del1_q         <= 33'd0;
         dur1_q         <= 33'd0;
         thhv_q         <= 8'd0;
         res_q          <= 8'd0;
         load_pulse_q   <= 1'b0;
         params_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
         err_cnt_q      <= 8'd0;
         echo_req_q     <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         rx_ready_q   <= bus.rx_ready;
         load_pulse_q <= 1'b0;
         frame_err_q  <= 1'b0;
         echo_req_q   <= 1'b0;

         case (state)
            IDLE: begin
               if (rx_edge_p0) begin
                  if (rx_byte_p0 == SYNC_BYTE) begin
                     state   <= PAYLOAD;
                     busy_q  <= 1'b1;
                     idx     <= 4'd0;
                     csum    <= 8'd0;
                     tmo_cnt <= '0;
                  end else if (rx_byte_p0 == ECHO_BYTE) begin
                     echo_req_q <= 1'b1;
                  end
               end
            end

            PAYLOAD: begin
               if (rx_edge_p0) begin
                  csum    <= csum ^ rx_byte_p0;
                  idx     <= idx + 4'd1;
                  tmo_cnt <= '0;
                  if (idx == 4'd9) state <= CHECK;
               end else if (tmo_hit_p0) begin
                  frame_err_q <= 1'b1;
                  err_cnt_q   <= sat_inc8(err_cnt_q);
                  state       <= IDLE;
                  busy_q      <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            CHECK: begin
               if (rx_edge_p0) begin
                  if (rx_byte_p0 == csum) begin
                     del1_q         <= {1'b0, shadow[0], shadow[1], shadow[2], shadow[3]};
                     dur1_q         <= {1'b0, shadow[4], shadow[5], shadow[6], shadow[7]};
                     thhv_q         <= shadow[8];
                     res_q          <= shadow[9];
                     load_pulse_q   <= 1'b1;
                     params_valid_q <= 1'b1;
                  end else begin
                     frame_err_q <= 1'b1;
                     err_cnt_q   <= sat_inc8(err_cnt_q);
                  end
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else if (tmo_hit_p0) begin
                  frame_err_q <= 1'b1;
                  err_cnt_q   <= sat_inc8(err_cnt_q);
                  state       <= IDLE;
                  busy_q      <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.del1         = del1_q;
   assign bus.dur1         = dur1_q;
   assign bus.thhv         = thhv_q;
   assign bus.res_value    = res_q;
   assign bus.load_pulse   = load_pulse_q;
   assign bus.params_valid = params_valid_q;
   assign bus.frame_err    = frame_err_q;
   assign bus.err_cnt      = err_cnt_q;
   assign bus.echo_req     = echo_req_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_uart_param_frame_loader.sv
// Directed and randomized frames against a frame-level reference model.
module tb_uart_param_frame_loader;

   localparam int unsigned T = 100;

   logic clk;
   logic reset;
   uart_param_frame_loader_if bus_if();

   uart_param_frame_loader #(
      .TIMEOUT_CYCLES(T),
      .SYNC_BYTE     (8'hA5),
      .ECHO_BYTE     (8'h72),
      .REVERSE_BITS  (1'b1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Strobe monitor
   int n_load = 0, n_err = 0, n_echo = 0, n_both = 0, n_long = 0;
   logic prev_load = 1'b0, prev_err = 1'b0, prev_echo = 1'b0;
   always @(negedge clk) begin
      if (bus_if.load_pulse) n_load <= n_load + 1;
      if (bus_if.frame_err)  n_err  <= n_err + 1;
      if (bus_if.echo_req)   n_echo <= n_echo + 1;
      if (bus_if.load_pulse && bus_if.frame_err) n_both <= n_both + 1;
      if ((bus_if.load_pulse && prev_load) || (bus_if.frame_err && prev_err) ||
          (bus_if.echo_req && prev_echo)) n_long <= n_long + 1;
      prev_load <= bus_if.load_pulse;
      prev_err  <= bus_if.frame_err;
      prev_echo <= bus_if.echo_req;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Frame-level reference model state
   logic [7:0]  fr [12];
   logic [32:0] exp_del1, exp_dur1;
   logic [7:0]  exp_thhv, exp_res, exp_errcnt;
   logic        exp_valid;
   int          exp_loads, exp_errs;

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
      bus_if.rx_data  = rev8(b);
      bus_if.rx_ready = 1'b1;
      repeat (hold) tick();
      bus_if.rx_ready = 1'b0;
      bus_if.rx_data  = 8'($urandom);
      repeat (gap) tick();
   endtask

   function automatic logic [7:0] payload_xor();
      logic [7:0] x = 8'd0;
      for (int i = 1; i <= 10; i++) x = x ^ fr[i];
      return x;
   endfunction

   task automatic build_random(input bit good);
      fr[0] = 8'hA5;
      for (int i = 1; i <= 10; i++) fr[i] = 8'($urandom);
      fr[11] = good ? payload_xor() : payload_xor() ^ 8'($urandom_range(1, 255));
   endtask

   task automatic send_frame(input bit fast);
      for (int i = 0; i < 12; i++) begin
         if (fast) send_byte(fr[i], 1, 1);
         else      send_byte(fr[i], $urandom_range(1, 3), $urandom_range(1, 3));
      end
   endtask

   task automatic model_frame();
      if (fr[11] == payload_xor()) begin
         exp_del1  = {1'b0, fr[1], fr[2], fr[3], fr[4]};
         exp_dur1  = {1'b0, fr[5], fr[6], fr[7], fr[8]};
         exp_thhv  = fr[9];
         exp_res   = fr[10];
         exp_valid = 1'b1;
         exp_loads++;
      end else begin
         model_error();
      end
   endtask

   task automatic model_error();
      if (exp_errcnt < 8'd255) exp_errcnt = exp_errcnt + 8'd1;
      exp_errs++;
   endtask

   task automatic model_reset();
      exp_del1 = '0; exp_dur1 = '0; exp_thhv = '0; exp_res = '0;
      exp_errcnt = '0; exp_valid = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_del1"},  64'(bus_if.del1),         64'(exp_del1));
      check({tag, "_dur1"},  64'(bus_if.dur1),         64'(exp_dur1));
      check({tag, "_thhv"},  64'(bus_if.thhv),         64'(exp_thhv));
      check({tag, "_res"},   64'(bus_if.res_value),    64'(exp_res));
      check({tag, "_valid"}, 64'(bus_if.params_valid), 64'(exp_valid));
      check({tag, "_errc"},  64'(bus_if.err_cnt),      64'(exp_errcnt));
      check({tag, "_busy"},  64'(bus_if.busy),         64'd0);
   endtask

   int base_echo, base_err, base_load;
   logic [7:0] junk;

   initial begin
      exp_loads = 0; exp_errs = 0;
      model_reset();

      // Reset with rx_ready already high carrying a sync byte
      reset = 1'b0;
      bus_if.rx_ready = 1'b1;
      bus_if.rx_data  = rev8(8'hA5);
      repeat (3) tick();
      reset = 1'b1;
      repeat (20) tick();
      check_outputs("rst");
      check("rst_loads", 64'(n_load), 64'd0);
      check("rst_echo",  64'(n_echo), 64'd0);
      check("rst_errs",  64'(n_err),  64'd0);
      bus_if.rx_ready = 1'b0;
      tick();

      // Known frame with exact load latency
      fr = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'hF4, 8'h00, 8'h00, 8'h03, 8'hE8, 8'h10, 8'h7F, 8'h71};
      for (int i = 0; i < 11; i++) send_byte(fr[i], 1 + i % 3, 1 + i % 2);
      bus_if.rx_data  = rev8(fr[11]);
      bus_if.rx_ready = 1'b1;
      @(negedge clk);
      check("latN_load", 64'(bus_if.load_pulse), 64'd0);
      check("latN_del1", 64'(bus_if.del1), 64'd0);
      @(negedge clk);
      check("latN1_load",  64'(bus_if.load_pulse),   64'd1);
      check("latN1_del1",  64'(bus_if.del1),         64'd500);
      check("latN1_dur1",  64'(bus_if.dur1),         64'd1000);
      check("latN1_thhv",  64'(bus_if.thhv),         64'h10);
      check("latN1_res",   64'(bus_if.res_value),    64'h7F);
      check("latN1_valid", 64'(bus_if.params_valid), 64'd1);
      @(negedge clk);
      check("latN2_load", 64'(bus_if.load_pulse), 64'd0);
      bus_if.rx_ready = 1'b0;
      tick(); tick();
      model_frame();
      check_outputs("frameA");

      // Same frame, corrupted checksum
      base_err = n_err;
      fr[11] = 8'h71 ^ 8'h01;
      send_frame(1'b0);
      tick();
      model_frame();
      check("badcs_errs", 64'(n_err - base_err), 64'd1);
      check_outputs("badcs");

      // Timeout after sync plus three payload bytes
      send_byte(8'hA5, 2, 1);
      send_byte(8'h12, 1, 2);
      send_byte(8'h34, 3, 1);
      bus_if.rx_data  = rev8(8'h56);
      bus_if.rx_ready = 1'b1;
      tick();
      bus_if.rx_ready = 1'b0;
      for (int j = 1; j <= int'(T) + 1; j++) begin
         @(negedge clk);
         if (j == int'(T)) begin
            check("tmo_before_err",  64'(bus_if.frame_err), 64'd0);
            check("tmo_before_busy", 64'(bus_if.busy),      64'd1);
         end else if (j == int'(T) + 1) begin
            check("tmo_at_err",  64'(bus_if.frame_err), 64'd1);
            check("tmo_at_busy", 64'(bus_if.busy),      64'd0);
         end
      end
      @(negedge clk);
      check("tmo_after_err", 64'(bus_if.frame_err), 64'd0);
      tick();
      model_error();
      build_random(1'b1);
      send_frame(1'b0);
      tick();
      model_frame();
      check_outputs("post_tmo");

      // Echo query in IDLE, then echo/sync values as payload data
      base_echo = n_echo;
      send_byte(8'h72, 2, 2);
      tick();
      check("echo_idle", 64'(n_echo - base_echo), 64'd1);
      base_echo = n_echo;
      base_load = n_load;
      build_random(1'b1);
      fr[3] = 8'h72; fr[5] = 8'hA5; fr[9] = 8'h72;
      fr[11] = payload_xor();
      send_frame(1'b0);
      tick();
      model_frame();
      check("echo_payload", 64'(n_echo - base_echo), 64'd0);
      check("echo_payload_load", 64'(n_load - base_load), 64'd1);
      check("echo_thhv", 64'(bus_if.thhv), 64'h72);
      check_outputs("echo_frame");

      // Randomized frames with idle junk
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 1) == 1) begin
            junk = 8'($urandom);
            if (junk == 8'hA5 || junk == 8'h72) junk = 8'h00;
            send_byte(junk, $urandom_range(1, 3), $urandom_range(1, 3));
         end
         build_random($urandom_range(0, 3) != 0);
         send_frame(1'b0);
         tick();
         model_frame();
         check_outputs("rand");
      end
      check("rand_loads", 64'(n_load), 64'(exp_loads));
      check("rand_errs",  64'(n_err),  64'(exp_errs));

      // Error counter saturation
      for (int k = 0; k < 260; k++) begin
         build_random(1'b0);
         send_frame(1'b1);
         model_frame();
      end
      tick();
      check("sat_errcnt", 64'(bus_if.err_cnt), 64'd255);
      check("sat_errs",   64'(n_err), 64'(exp_errs));
      check_outputs("sat");
      check("strobe_both", 64'(n_both), 64'd0);
      check("strobe_long", 64'(n_long), 64'd0);

      // Reset in the middle of a frame
      build_random(1'b1);
      for (int i = 0; i < 6; i++) send_byte(fr[i], 1, 1);
      reset = 1'b0;
      tick(); tick();
      model_reset();
      check_outputs("midrst");
      reset = 1'b1;
      tick();
      build_random(1'b1);
      send_frame(1'b0);
      tick();
      model_frame();
      check_outputs("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
